// File: rtl/acq_sequencer.sv
// Acquisition sequencer: arms the sampler per trigger mode, forces a trigger on auto timeout,
// and streams the circular sample buffer back oldest-first over a valid/ready port.
`timescale 1ns / 1ps
module acq_sequencer #(
  parameter int unsigned SAMPLE_DEPTH = 8,
  parameter int unsigned AUTO_TIMEOUT = 5_000_000,
  parameter int unsigned HOLDOFF      = 1000
) (
  input  logic                    clk_50mhz,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic                    arm,
  output logic                    smp_activate,
  input  logic                    smp_done,
  output logic                    smp_force_trig,
  input  logic [SAMPLE_DEPTH-1:0] trig_offset,
  output logic [SAMPLE_DEPTH-1:0] rd_addr,
  input  logic [7:0]              rd_data,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    auto_flag
);

  localparam logic [1:0] ModeStop   = 2'd0;
  localparam logic [1:0] ModeSingle = 2'd1;
  localparam logic [1:0] ModeNormal = 2'd2;
  localparam logic [1:0] ModeAuto   = 2'd3;

  localparam int unsigned CntW   = SAMPLE_DEPTH + 1;
  localparam int unsigned TmrMax = (AUTO_TIMEOUT > HOLDOFF) ? AUTO_TIMEOUT : HOLDOFF;
  localparam int unsigned TmrW   = $clog2(TmrMax);

  localparam logic [CntW-1:0]         LastCnt = CntW'((1 << SAMPLE_DEPTH) - 1);
  localparam logic [TmrW-1:0]         AutoEnd = TmrW'(AUTO_TIMEOUT - 1);
  localparam logic [TmrW-1:0]         HoldEnd = TmrW'(HOLDOFF - 1);
  // Trigger sits mid-buffer, so the oldest sample is half a buffer past it.
  localparam logic [SAMPLE_DEPTH-1:0] HalfOff = {1'b1, {(SAMPLE_DEPTH-1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle, StArm, StWaitDone, StFetch, StLatch, StSend, StHoldoff, StDrain
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              run_mode_q, run_mode_d;
  logic [TmrW-1:0]         tmr_q, tmr_d;
  logic [CntW-1:0]         count_q, count_d;
  logic [SAMPLE_DEPTH-1:0] start_q, start_d;
  logic                    done_prev_q;
  logic                    auto_flag_q, auto_flag_d;
  logic [7:0]              out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic                    done_rise;

  assign done_rise = smp_done & ~done_prev_q;

  always_comb begin
    state_d        = state_q;
    run_mode_d     = run_mode_q;
    tmr_d          = tmr_q;
    count_d        = count_q;
    start_d        = start_q;
    auto_flag_d    = auto_flag_q;
    out_data_d     = out_data_q;
    out_valid_d    = out_valid_q;
    out_last_d     = out_last_q;
    smp_activate   = 1'b0;
    smp_force_trig = 1'b0;

    unique case (state_q)
      StIdle: begin
        if ((mode == ModeSingle && arm) || mode == ModeNormal || mode == ModeAuto) begin
          state_d = StArm;
        end
      end
      StArm: begin
        smp_activate = 1'b1;
        tmr_d        = '0;
        auto_flag_d  = 1'b0;
        run_mode_d   = mode;
        state_d      = StWaitDone;
      end
      StWaitDone: begin
        // A completed capture wins over a concurrent stop so DRAIN never waits on a spent edge.
        if (done_rise) begin
          start_d = trig_offset + HalfOff;
          count_d = '0;
          state_d = StFetch;
        end else if (mode == ModeStop) begin
          smp_force_trig = 1'b1;
          state_d        = StDrain;
        end else if (run_mode_q == ModeAuto) begin
          if (tmr_q == AutoEnd) begin
            if (!auto_flag_q) begin
              smp_force_trig = 1'b1;
              auto_flag_d    = 1'b1;
            end
          end else begin
            tmr_d = tmr_q + TmrW'(1);
          end
        end
      end
      StDrain: begin
        if (done_rise) begin
          state_d = StIdle;
        end
      end
      StFetch: begin
        state_d = StLatch;
      end
      StLatch: begin
        out_data_d  = rd_data;
        out_valid_d = 1'b1;
        out_last_d  = (count_q == LastCnt);
        state_d     = StSend;
      end
      StSend: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            if (run_mode_q == ModeNormal || run_mode_q == ModeAuto) begin
              tmr_d   = '0;
              state_d = StHoldoff;
            end else begin
              state_d = StIdle;
            end
          end else begin
            count_d = count_q + CntW'(1);
            state_d = StFetch;
          end
        end
      end
      StHoldoff: begin
        if (tmr_q == HoldEnd) begin
          state_d = (mode == ModeStop || mode == ModeSingle) ? StIdle : StArm;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      state_q     <= StIdle;
      run_mode_q  <= ModeStop;
      tmr_q       <= '0;
      count_q     <= '0;
      start_q     <= '0;
      done_prev_q <= 1'b0;
      auto_flag_q <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_mode_q  <= run_mode_d;
      tmr_q       <= tmr_d;
      count_q     <= count_d;
      start_q     <= start_d;
      done_prev_q <= smp_done;
      auto_flag_q <= auto_flag_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign rd_addr   = start_q + count_q[SAMPLE_DEPTH-1:0];
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign auto_flag = auto_flag_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_acq_sequencer.sv
// Randomized bench for acq_sequencer: a RAM/sampler model feeds the DUT, a scoreboard queue
// holds the expected time-ordered frame, and a negedge monitor checks every handshake.
`timescale 1ns / 1ps
module tb_acq_sequencer;
  localparam int unsigned SD = 8;
  localparam int unsigned AT = 100;
  localparam int unsigned HO = 10;

  logic          clk_50mhz = 1'b0;
  logic          reset;
  logic [1:0]    mode;
  logic          arm;
  logic          smp_activate;
  logic          smp_done;
  logic          smp_force_trig;
  logic [SD-1:0] trig_offset;
  logic [SD-1:0] rd_addr;
  logic [7:0]    rd_data = 8'h00;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          auto_flag;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         hs_cnt = 0;
  int         force_cnt = 0;
  int         force_cyc = 0;
  int         last_hs_cyc = 0;
  bit         bp_en = 1'b0;
  logic [8:0] exp_q[$];
  logic [7:0] ram[256];

  acq_sequencer #(
    .SAMPLE_DEPTH(SD),
    .AUTO_TIMEOUT(AT),
    .HOLDOFF     (HO)
  ) dut (
    .clk_50mhz     (clk_50mhz),
    .reset         (reset),
    .mode          (mode),
    .arm           (arm),
    .smp_activate  (smp_activate),
    .smp_done      (smp_done),
    .smp_force_trig(smp_force_trig),
    .trig_offset   (trig_offset),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .busy          (busy),
    .auto_flag     (auto_flag)
  );

  initial forever #5 clk_50mhz = ~clk_50mhz;

  initial forever begin
    @(posedge clk_50mhz);
    cyc++;
  end

  // Synchronous-read sample RAM.
  initial forever begin
    @(posedge clk_50mhz);
    rd_data <= ram[rd_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out at cycle %0d", name, cyc);
  endtask

  task automatic step();
    @(posedge clk_50mhz);
    #1;
    if (bp_en) out_ready = ($urandom_range(0, 9) < 3);
  endtask

  // Fresh RAM contents (a bijection of the address) and the expected oldest-first frame.
  task automatic push_frame(input int trig);
    logic [7:0] key;
    int         addr;
    key = 8'($urandom);
    for (int a = 0; a < 256; a++) ram[a] = 8'(a) ^ key;
    for (int i = 0; i < 256; i++) begin
      addr = (trig + 128 + i) % 256;
      exp_q.push_back({(i == 255), ram[addr]});
    end
  endtask

  task automatic wait_activate(input string name);
    for (int i = 0; i < 300; i++) begin
      step();
      if (smp_activate) return;
    end
    fail_timeout(name);
  endtask

  task automatic wait_drained(input string name);
    for (int i = 0; i < 8000; i++) begin
      step();
      if (exp_q.size() == 0) return;
    end
    fail_timeout(name);
    exp_q.delete();
  endtask

  // Called in the ARM cycle: stop while waiting must force once, emit nothing, then idle.
  task automatic stop_in_wait(input string name);
    int f0;
    f0 = force_cnt;
    mode = 2'd0;
    smp_done = 1'b0;
    step();
    chk({name, " auto_flag cleared"}, 32'(auto_flag), 0);
    repeat (4) step();
    chk({name, " one force"}, 32'(force_cnt - f0), 1);
    chk({name, " draining busy"}, 32'(busy), 1);
    smp_done = 1'b1;
    step();
    chk({name, " idle after drain"}, 32'(busy), 0);
  endtask

  initial begin : monitor
    logic       stall_prev;
    logic [8:0] stall_word;
    logic [8:0] req;
    stall_prev = 1'b0;
    stall_word = '0;
    forever begin
      @(negedge clk_50mhz);
      if (!reset) begin
        if (smp_activate && smp_force_trig) chk("activate/force overlap", 1, 0);
        if (smp_force_trig) begin
          force_cnt++;
          force_cyc = cyc;
        end
        if (out_valid && stall_prev) chk("stalled output stable", {out_last, out_data}, stall_word);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected byte", {out_last, out_data}, 32'h1ff00);
          end else begin
            req = exp_q.pop_front();
            chk("frame byte", {out_last, out_data}, req);
          end
          hs_cnt++;
          last_hs_cyc = cyc;
        end
        stall_prev = out_valid && !out_ready;
        stall_word = {out_last, out_data};
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;
    int a0;
    int f0;
    int trig;
    reset = 1'b1;
    mode = 2'd0;
    arm = 1'b0;
    smp_done = 1'b0;
    trig_offset = '0;
    out_ready = 1'b1;
    repeat (3) step();
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset out_data", 32'(out_data), 0);
    chk("reset out_last", 32'(out_last), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset auto_flag", 32'(auto_flag), 0);
    chk("reset rd_addr", 32'(rd_addr), 0);
    chk("reset activate/force", {smp_activate, smp_force_trig}, 0);
    reset = 1'b0;

    // Single, trig 0x10, no backpressure, with latency checks.
    mode = 2'd1;
    step();
    step();
    chk("single waits for arm", 32'(busy), 0);
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk("activate one cycle after arm", 32'(smp_activate), 1);
    repeat (3) step();
    push_frame(8'h10);
    h0 = hs_cnt;
    trig_offset = 8'h10;
    smp_done = 1'b1;
    step();
    chk("first rd_addr trig 0x10", 32'(rd_addr), 32'h90);
    step();
    chk("no valid at d+2", 32'(out_valid), 0);
    step();
    chk("first valid at d+3", 32'(out_valid), 1);
    wait_drained("single frame");
    chk("single ends idle", 32'(busy), 0);
    chk("single byte count", 32'(hs_cnt - h0), 256);

    // Single, wrap case, 30% ready duty.
    arm = 1'b1;
    step();
    arm = 1'b0;
    smp_done = 1'b0;
    bp_en = 1'b1;
    repeat (2) step();
    push_frame(8'hF0);
    h0 = hs_cnt;
    trig_offset = 8'hF0;
    smp_done = 1'b1;
    step();
    chk("first rd_addr trig 0xF0", 32'(rd_addr), 32'h70);
    wait_drained("backpressure frame");
    bp_en = 1'b0;
    out_ready = 1'b1;
    chk("backpressure ends idle", 32'(busy), 0);
    chk("backpressure byte count", 32'(hs_cnt - h0), 256);

    // Normal mode: re-arm after holdoff, then stop while waiting.
    mode = 2'd2;
    wait_activate("normal first activate");
    smp_done = 1'b0;
    f0 = force_cnt;
    repeat (5) step();
    trig = int'($urandom_range(0, 255));
    push_frame(trig);
    h0 = hs_cnt;
    trig_offset = 8'(trig);
    smp_done = 1'b1;
    wait_drained("normal frame");
    chk("normal byte count", 32'(hs_cnt - h0), 256);
    chk("normal no force", 32'(force_cnt - f0), 0);
    chk("normal auto_flag", 32'(auto_flag), 0);
    wait_activate("normal re-arm");
    chk("normal re-arm delay", 32'(cyc - last_hs_cyc), HO + 1);
    stop_in_wait("normal stop");

    // Auto mode: forced trigger after timeout, stream, re-arm, stop.
    mode = 2'd3;
    wait_activate("auto activate");
    a0 = cyc;
    smp_done = 1'b0;
    f0 = force_cnt;
    for (int i = 0; i < 400 && force_cnt == f0; i++) step();
    if (force_cnt == f0) fail_timeout("auto force");
    chk("auto force timing", 32'(force_cyc - a0), AT);
    step();
    chk("auto_flag set", 32'(auto_flag), 1);
    repeat (5) step();
    chk("auto single force", 32'(force_cnt - f0), 1);
    trig = int'($urandom_range(0, 255));
    push_frame(trig);
    h0 = hs_cnt;
    trig_offset = 8'(trig);
    smp_done = 1'b1;
    wait_drained("auto frame");
    chk("auto byte count", 32'(hs_cnt - h0), 256);
    chk("auto_flag held", 32'(auto_flag), 1);
    wait_activate("auto re-arm");
    chk("auto re-arm delay", 32'(cyc - last_hs_cyc), HO + 1);
    stop_in_wait("auto stop");

    // Reset in the middle of a single frame, then a clean frame.
    mode = 2'd1;
    arm = 1'b1;
    step();
    arm = 1'b0;
    smp_done = 1'b0;
    step();
    trig = int'($urandom_range(0, 255));
    push_frame(trig);
    h0 = hs_cnt;
    trig_offset = 8'(trig);
    smp_done = 1'b1;
    for (int i = 0; i < 2000 && (hs_cnt - h0) < 100; i++) step();
    chk("bytes before reset", 32'(hs_cnt - h0), 100);
    reset = 1'b1;
    out_ready = 1'b0;
    step();
    chk("mid reset out_valid", 32'(out_valid), 0);
    chk("mid reset out_data", 32'(out_data), 0);
    chk("mid reset out_last", 32'(out_last), 0);
    chk("mid reset busy", 32'(busy), 0);
    chk("mid reset rd_addr", 32'(rd_addr), 0);
    chk("mid reset activate/force", {smp_activate, smp_force_trig}, 0);
    exp_q.delete();
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    chk("no valid after reset", 32'(out_valid), 0);
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk("activate after reset", 32'(smp_activate), 1);
    smp_done = 1'b0;
    step();
    trig = int'($urandom_range(0, 255));
    push_frame(trig);
    h0 = hs_cnt;
    trig_offset = 8'(trig);
    smp_done = 1'b1;
    wait_drained("post-reset frame");
    chk("post-reset byte count", 32'(hs_cnt - h0), 256);
    chk("post-reset idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acq_sequencer.md
# acq_sequencer

Acquisition sequencer that owns the sampler and its 256-byte sample RAM read port. It arms the sampler according to the trigger mode (single, normal, auto), forces a trigger on auto timeout, and reads the circular buffer back in time order. Readout starts at the oldest sample, which removes the trigger-offset rotation, and streams bytes to the host/display side over a valid/ready interface.

## Interface
- SAMPLE_DEPTH, 8, address width; buffer holds 2^SAMPLE_DEPTH samples.
- AUTO_TIMEOUT, 5_000_000, cycles in WAIT_DONE before forced trigger in auto mode (100 ms at 50 MHz); ≥ 2.
- HOLDOFF, 1000, idle cycles between frame end and re-arm in normal/auto; ≥ 1.

Ports:
- clk_50mhz  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- mode  in  2  0 stop, 1 single, 2 normal, 3 auto
- arm  in  1  one-cycle pulse; starts one frame in single mode
- smp_activate  out  1  one-cycle pulse to sampler
- smp_done  in  1  sampler done level; sequencer acts on its rising edge
- smp_force_trig  out  1  one-cycle pulse forcing sampler trigger
- trig_offset  in  SAMPLE_DEPTH  sampler trigger address, valid on smp_done rise
- rd_addr  out  SAMPLE_DEPTH  sample RAM read address
- rd_data  in  8  RAM data, valid one cycle after rd_addr
- out_data  out  8  sample byte
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts
- out_last  out  1  high with final byte of frame
- busy  out  1  state != IDLE
- auto_flag  out  1  current/last frame was force-triggered

## Operation
- States: IDLE, ARM, WAIT_DONE, FETCH, LATCH, SEND, HOLDOFF, DRAIN.
- IDLE: single mode and arm → ARM. Normal/auto → ARM immediately. Stop or no arm → stay. arm outside IDLE is ignored.
- ARM: smp_activate=1 for this cycle. Clear timeout counter and auto_flag. Latch mode into run_mode. → WAIT_DONE.
- WAIT_DONE: wait for smp_done rising edge, detected against a registered previous value. On the edge, latch start = (trig_offset + 2^(SAMPLE_DEPTH-1)) mod 2^SAMPLE_DEPTH, clear sample count → FETCH.
  - Auto: counter increments each cycle. When it reaches AUTO_TIMEOUT-1, smp_force_trig=1 for one cycle and auto_flag←1. This fires once per frame.
  - Live mode becomes stop while waiting: smp_force_trig pulses once → DRAIN.
- DRAIN: wait for smp_done rising edge, discard the frame → IDLE. No bytes are emitted.
- FETCH: rd_addr = start + count (mod 2^SAMPLE_DEPTH, natural wrap) → LATCH.
- LATCH: out_data←rd_data, out_valid←1, out_last←(count == 2^SAMPLE_DEPTH-1) → SEND.
- SEND: hold out_data/out_valid/out_last stable until out_ready. On the handshake cycle, out_valid←0 and out_last←0 at the next edge. Last byte → HOLDOFF (normal/auto) or IDLE (single). Otherwise count+1 → FETCH.
- Readout always completes. Mode changes during FETCH/LATCH/SEND are ignored.
- HOLDOFF: count HOLDOFF cycles. Live mode stop or single → IDLE. Otherwise → ARM.
- Count is SAMPLE_DEPTH+1 bits wide or compared before increment; no overflow aliasing.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, start 0, previous smp_done register 0.
- Reset mid-frame aborts at the next edge with no further out_valid. The sampler is not reset by this block.
- arm at cycle t (IDLE, single): smp_activate high at t+1.
- smp_done edge seen at cycle d: first rd_addr at d+1, first out_valid at d+3.
- Per byte: minimum 3 cycles (FETCH, LATCH, SEND with out_ready=1). A frame takes ≥ 768 cycles.
- smp_activate and smp_force_trig are never high in the same cycle. Neither is high outside ARM/WAIT_DONE.
- out_data never changes while out_valid=1 and out_ready=0.

## Test plan
- Single, trig_offset=0x10, out_ready=1: exactly 256 bytes. rd_addr sequence 0x90..0xFF, 0x00..0x8F. out_last only on byte 256. Ends in IDLE with busy=0.
- Wrap: trig_offset=0xF0 → first rd_addr 0x70. Bytes match RAM model in order. No duplicate or missing address.
- Backpressure: out_ready random 30% duty → out_data stable while stalled, 256 handshakes, same byte order as unstalled run.
- Auto, AUTO_TIMEOUT=100, no smp_done: smp_force_trig one pulse exactly 100 cycles after entering WAIT_DONE. auto_flag=1. After the done edge the frame streams, then re-arms after HOLDOFF.
- Normal, HOLDOFF=10: second smp_activate 11 cycles after the last handshake. Switching mode to stop in WAIT_DONE → one force_trig, zero bytes, IDLE.
- Reset asserted at byte 100: next cycle all outputs 0, state IDLE. A subsequent single arm produces a full 256-byte frame.
